// File: rtl/processor_pkg.sv
// Shared definitions for the data-memory responder: state encoding, word size
// and the request classification used at acceptance.
package processor_pkg;

    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } resp_state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_MISALIGN  = 2'd1,
        ERR_RANGE     = 2'd2,
        ERR_MALFORMED = 2'd3
    } err_cause_e;

    // The offset is taken modulo 2^32, so addresses below the base wrap to huge offsets.
    function automatic err_cause_e classify_req(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] span,
        input logic        rd,
        input logic        wr
    );
        err_cause_e cause;
        logic [31:0] offset;
        offset = addr - base;
        if (addr[1:0] != 2'd0) begin
            cause = ERR_MISALIGN;
        end else if (offset >= span) begin
            cause = ERR_RANGE;
        end else if (rd == wr) begin
            cause = ERR_MALFORMED;
        end else begin
            cause = ERR_NONE;
        end
        return cause;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Memory-stage request/acknowledge bundle between the processor and the responder.
interface data_mem_responder_if;
    logic        MemEnable;
    logic        MemRd;
    logic        MemWr;
    logic [31:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        MemDone;
    logic        MemErr;
    logic        busy;

    modport master (
        output MemEnable, MemRd, MemWr, address, data_in,
        input  data_out, MemDone, MemErr, busy
    );

    modport slave (
        input  MemEnable, MemRd, MemWr, address, data_in,
        output data_out, MemDone, MemErr, busy
    );
endinterface

// File: rtl/mem_word_array.sv
// Single-port word storage: synchronous write, synchronous enabled read into a
// held output register. Storage itself is never reset.
module mem_word_array #(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] index,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem_r [DEPTH];
    logic [31:0] rdata_r;

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[index] <= wdata;
        end
    end

    // Read register holds the last successful read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_r <= 32'd0;
        end else if (re) begin
            rdata_r <= mem_r[index];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory target with configurable wait states, a one-cycle
// MemDone acknowledge and MemErr reporting for bad requests.
module data_mem_responder
    import processor_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
    localparam logic [31:0]      SPAN     = 32'(DEPTH * WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_LOAD = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : CNT_W'(0);

    resp_state_e      state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0] idx_r, req_idx_s, bus_idx_s;
    logic [31:0]      wdata_r, req_wdata_s;
    logic             wr_r, req_wr_s;
    logic             err_r, req_err_s, bus_err_s;
    logic             done_r, merr_r, busy_r;
    logic             accept_s, enter_done_s, mem_we_s, mem_re_s;
    logic [31:0]      mem_rdata_s;

    assign bus_err_s = (classify_req(bus.address, BASE_ADDR, SPAN, bus.MemRd, bus.MemWr) != ERR_NONE);
    assign bus_idx_s = IDX_W'((bus.address - BASE_ADDR) >> 2);
    assign accept_s  = (state_r == IDLE) && bus.MemEnable;

    // With LATENCY=1 the array is touched on the acceptance edge itself, so the
    // live bus request is used in IDLE and the latched copy afterwards.
    always_comb begin
        if (state_r == IDLE) begin
            req_idx_s   = bus_idx_s;
            req_wdata_s = bus.data_in;
            req_wr_s    = bus.MemWr;
            req_err_s   = bus_err_s;
        end else begin
            req_idx_s   = idx_r;
            req_wdata_s = wdata_r;
            req_wr_s    = wr_r;
            req_err_s   = err_r;
        end
    end

    // Next-state and wait counter
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (bus.MemEnable) begin
                    if (LATENCY > 1) begin
                        state_nxt_s = WAIT;
                        cnt_nxt_s   = CNT_LOAD;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == CNT_W'(0)) begin
                    state_nxt_s = DONE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = CNT_W'(0);
            end
        endcase
    end

    assign enter_done_s = (state_nxt_s == DONE) && (state_r != DONE);
    assign mem_we_s     = enter_done_s && !req_err_s && req_wr_s && reset;
    assign mem_re_s     = enter_done_s && !req_err_s && !req_wr_s;

    // State, request latch and registered handshake outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_W'(0);
            idx_r   <= IDX_W'(0);
            wdata_r <= 32'd0;
            wr_r    <= 1'b0;
            err_r   <= 1'b0;
            done_r  <= 1'b0;
            merr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (accept_s) begin
                idx_r   <= bus_idx_s;
                wdata_r <= bus.data_in;
                wr_r    <= bus.MemWr;
                err_r   <= bus_err_s;
            end
            done_r <= enter_done_s;
            merr_r <= enter_done_s && req_err_s;
            busy_r <= (state_nxt_s != IDLE);
        end
    end

    mem_word_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (mem_we_s),
        .re    (mem_re_s),
        .index (req_idx_s),
        .wdata (req_wdata_s),
        .rdata (mem_rdata_s)
    );

    assign bus.data_out = mem_rdata_s;
    assign bus.MemDone  = done_r;
    assign bus.MemErr   = merr_r;
    assign bus.busy     = busy_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: three parameterisations driven
// one at a time against an associative-array memory model.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en, rd, wr;
    logic [31:0] addr, wdat;
    int          sel;

    logic        o_done, o_err, o_busy;
    logic [31:0] o_dout;

    data_mem_responder_if if_a ();
    data_mem_responder_if if_b ();
    data_mem_responder_if if_c ();

    data_mem_responder #(.DEPTH(256), .LATENCY(2), .BASE_ADDR(32'h0000_0000))
        dut_a (.clk(clk), .reset(rst_n), .bus(if_a.slave));
    data_mem_responder #(.DEPTH(256), .LATENCY(1), .BASE_ADDR(32'h0000_1000))
        dut_b (.clk(clk), .reset(rst_n), .bus(if_b.slave));
    data_mem_responder #(.DEPTH(256), .LATENCY(5), .BASE_ADDR(32'h0000_1000))
        dut_c (.clk(clk), .reset(rst_n), .bus(if_c.slave));

    always_comb begin
        if_a.MemEnable = en && (sel == 0);
        if_b.MemEnable = en && (sel == 1);
        if_c.MemEnable = en && (sel == 2);
        if_a.MemRd = rd;   if_b.MemRd = rd;   if_c.MemRd = rd;
        if_a.MemWr = wr;   if_b.MemWr = wr;   if_c.MemWr = wr;
        if_a.address = addr; if_b.address = addr; if_c.address = addr;
        if_a.data_in = wdat; if_b.data_in = wdat; if_c.data_in = wdat;
    end

    always_comb begin
        case (sel)
            1: begin o_done = if_b.MemDone; o_err = if_b.MemErr; o_busy = if_b.busy; o_dout = if_b.data_out; end
            2: begin o_done = if_c.MemDone; o_err = if_c.MemErr; o_busy = if_c.busy; o_dout = if_c.data_out; end
            default: begin o_done = if_a.MemDone; o_err = if_a.MemErr; o_busy = if_a.busy; o_dout = if_a.data_out; end
        endcase
    end

    int          lat  [3] = '{2, 1, 5};
    logic [31:0] base [3] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_1000};
    logic [31:0] model [int];
    logic [31:0] exp_dout [3];
    logic        pend_err;
    logic        nxt_rd, nxt_wr;
    logic [31:0] nxt_addr, nxt_wdat;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (dut %0d): got %h expected %h", tag, sel, got, exp);
        end
    endtask

    // Reference behaviour straight from the access rules.
    task automatic apply_model(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        int key;
        off = a - base[sel];
        pend_err = (a[1:0] != 2'd0) || (off >= 32'd1024) || (r == w);
        key = sel * 4096 + int'(off >> 2);
        if (!pend_err) begin
            if (w) model[key] = d;
            else if (model.exists(key)) exp_dout[sel] = model[key];
        end
    endtask

    task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        rd = r; wr = w; addr = a; wdat = d; en = 1'b1;
        @(posedge clk); #1;
        check_eq("accept_busy", 32'(o_busy), 32'd1);
        apply_model(r, w, a, d);
    endtask

    task automatic finish_txn(input logic hold);
        int k;
        if (!hold) en = 1'b0;
        k = 0;
        while (o_done !== 1'b1 && k < 20) begin
            if (hold) begin
                addr = $urandom; wdat = $urandom; rd = 1'($urandom); wr = 1'($urandom);
            end
            @(posedge clk); #1;
            k++;
        end
        check_eq("latency", 32'(k), 32'(lat[sel] - 1));
        check_eq("memerr", 32'(o_err), 32'(pend_err));
        check_eq("dout_at_done", o_dout, exp_dout[sel]);
        if (hold) begin
            rd = nxt_rd; wr = nxt_wr; addr = nxt_addr; wdat = nxt_wdat;
        end
        @(posedge clk); #1;
        check_eq("done_one_cycle", 32'(o_done), 32'd0);
        check_eq("busy_clear", 32'(o_busy), 32'd0);
        check_eq("dout_hold", o_dout, exp_dout[sel]);
    endtask

    task automatic txn(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        issue(r, w, a, d);
        finish_txn(1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pool [8] = '{0, 1, 2, 3, 4, 5, 254, 255};
        logic [31:0] a;
        rst_n = 1'b0; en = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'd0; wdat = 32'd0; sel = 0;
        for (int s = 0; s < 3; s++) exp_dout[s] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            check_eq("rst_dout", o_dout, 32'd0);
            check_eq("rst_done", 32'(o_done), 32'd0);
            check_eq("rst_err", 32'(o_err), 32'd0);
            check_eq("rst_busy", 32'(o_busy), 32'd0);
        end
        sel = 0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic write/read, read-then-write ordering, error cases
        txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        txn(1'b1, 1'b0, 32'h10, 32'h0);
        txn(1'b0, 1'b1, 32'h10, 32'h1234_5678);
        txn(1'b1, 1'b0, 32'h10, 32'h0);
        txn(1'b0, 1'b1, 32'h20, 32'h0BAD_C0DE);
        txn(1'b1, 1'b0, 32'h13, 32'h0);
        txn(1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF);
        txn(1'b1, 1'b1, 32'h10, 32'hAAAA_AAAA);
        txn(1'b0, 1'b0, 32'h10, 32'h5555_5555);
        txn(1'b1, 1'b0, 32'h10, 32'h0);

        // MemEnable held through WAIT with noise on the bus; back-to-back accept
        nxt_rd = 1'b1; nxt_wr = 1'b0; nxt_addr = 32'h14; nxt_wdat = 32'h0;
        issue(1'b0, 1'b1, 32'h14, 32'h55AA_33CC);
        finish_txn(1'b1);
        @(posedge clk); #1;
        check_eq("second_accept", 32'(o_busy), 32'd1);
        apply_model(1'b1, 1'b0, 32'h14, 32'h0);
        finish_txn(1'b0);

        // Reset in WAIT aborts the write of 0xCAFEF00D
        rd = 1'b0; wr = 1'b1; addr = 32'h20; wdat = 32'hCAFE_F00D; en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        check_eq("abort_busy_before", 32'(o_busy), 32'd1);
        rst_n = 1'b0; #1;
        check_eq("abort_dout", o_dout, 32'd0);
        check_eq("abort_busy", 32'(o_busy), 32'd0);
        check_eq("abort_done", 32'(o_done), 32'd0);
        for (int s = 0; s < 3; s++) exp_dout[s] = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("abort_no_done", 32'(o_done), 32'd0);
        end
        txn(1'b1, 1'b0, 32'h20, 32'h0);

        // Based instances: LATENCY 1 and 5, window 0x1000..0x13FF
        for (int s = 1; s < 3; s++) begin
            sel = s; #1;
            txn(1'b0, 1'b1, 32'h13FC, 32'h0F0F_1234 + 32'(s));
            txn(1'b1, 1'b0, 32'h13FC, 32'h0);
            txn(1'b1, 1'b0, 32'h0FFC, 32'h0);
            txn(1'b0, 1'b1, 32'h1400, 32'h7777_7777);
            txn(1'b1, 1'b0, 32'h13FC, 32'h0);
        end

        // Randomized traffic over a pre-filled pool plus assorted bad requests
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            for (int i = 0; i < 8; i++) txn(1'b0, 1'b1, base[s] + 32'(pool[i] * 4), $urandom);
            for (int i = 0; i < 40; i++) begin
                a = base[s] + 32'(pool[$urandom_range(0, 7)] * 4);
                case ($urandom_range(0, 9))
                    0: a = a + 32'($urandom_range(1, 3));
                    1: a = base[s] + 32'd1024 + 32'($urandom_range(0, 255) * 4);
                    2: a = base[s] - 32'd4;
                    default: a = a;
                endcase
                if ($urandom_range(0, 4) == 0) txn(1'($urandom), 1'($urandom), a, $urandom);
                else if ($urandom_range(0, 1) == 0) txn(1'b1, 1'b0, a, $urandom);
                else txn(1'b0, 1'b1, a, $urandom);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-addressed data-memory target that answers the processor's memory-stage requests (MemEnable/MemRd/MemWr, address, data_in) with configurable wait states.
- Returns read data and a one-cycle MemDone acknowledge, so the control unit advances from the memory stage on the ack rather than on a fixed cycle count.
- Flags misaligned, out-of-range and malformed requests with MemErr.

Parameters:
- DEPTH, 256, number of 32-bit words in the storage array (power of two, ≥ 2).
- LATENCY, 2, cycles from request acceptance to the MemDone pulse (≥ 1).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be DEPTH*4-aligned.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- MemEnable  input  1  request strobe from the memory stage.
- MemRd  input  1  read request qualifier.
- MemWr  input  1  write request qualifier.
- address  input  32  byte address of the access.
- data_in  input  32  write data.
- data_out  output  32  read data; registered and held until the next successful read.
- MemDone  output  1  one-cycle acknowledge that ends a transaction.
- MemErr  output  1  valid only while MemDone=1; high means the request failed.
- busy  output  1  high from acceptance until the cycle after MemDone.

Behaviour:
- Reset: while reset=0, state=IDLE, data_out=0, MemDone=0, MemErr=0, busy=0, wait counter=0. The storage array is not reset and its contents are undefined until written. Reset asserted mid-transaction aborts it: no array write, no MemDone.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - A rising edge with MemEnable=1 accepts the request. Latch address, data_in and op; set busy=1.
  - Error checks at acceptance:
    - address[1:0] != 0 is misaligned.
    - (address - BASE_ADDR) >= DEPTH*4 is out of range; use 32-bit unsigned arithmetic, so addresses below base wrap and fail.
    - MemRd = MemWr (both 1 or both 0) is malformed.
    - Any check failing marks the request as an error.
  - Next state: WAIT if LATENCY > 1, with the counter loaded to LATENCY-2. Otherwise DONE.
  - MemEnable=0: stay in IDLE.
- WAIT: decrement the counter each cycle; go to DONE when it is 0.
- Transition into DONE, on the same edge:
  - Good write: array[index] <= latched data.
  - Good read: data_out <= array[index].
  - Error: no array or data_out change.
  - index = (address - BASE_ADDR) >> 2, truncated to log2(DEPTH) bits.
- DONE:
  - MemDone=1 for exactly one cycle; MemErr reflects the latched error status.
  - Next state is IDLE; busy=0 from the following cycle.
- Latency: request sampled at edge N gives MemDone high during the cycle following edge N+LATENCY-1. That is LATENCY cycles of latency, plus one mandatory IDLE bubble before the next acceptance.
- Request handling while busy:
  - MemEnable, MemRd, MemWr, address and data_in are ignored while busy=1. The initiator may keep them asserted; only the IDLE sample counts.
  - If MemEnable is still high in the IDLE cycle after DONE, it is taken as a new request. The control unit must drop MemEnable on MemDone.
- data_out is never driven combinationally from the array and is unchanged by writes, including writes to the last-read address.

Decomposition:
- Shared package (processor_pkg):
  - responder state encoding: IDLE=2'd0, WAIT=2'd1, DONE=2'd2.
  - WORD_BYTES=4.
  - an error-cause enumeration for debug: MISALIGN, RANGE, MALFORMED.
- One sub-module, mem_word_array: DEPTH×32 synchronous-write, synchronous-read storage with a single port (we, index, wdata, rdata). The responder FSM owns all sequencing.

Test Plan:
- Reset=0 then 1; write 0xDEADBEEF to 0x10, then read 0x10 (LATENCY=2) -> MemDone 2 cycles after each acceptance, data_out=0xDEADBEEF, MemErr=0.
- Read 0x10, then write 0x12345678 to 0x10 -> data_out stays 0xDEADBEEF through the write's MemDone; a re-read returns 0x12345678.
- Read 0x13 (misaligned), 0x400 with DEPTH=256 (out of range), and MemRd=MemWr=1 -> each gives a single MemDone with MemErr=1, no array change (verified by reading 0x10), and data_out unchanged.
- Hold MemEnable=1 with varying address and data during WAIT -> only the first request completes; a second acceptance occurs exactly one cycle after MemDone.
- Assert reset=0 in WAIT during a write of 0xCAFEF00D to 0x20 -> outputs 0 immediately (asynchronous); no MemDone; a later read of 0x20 returns the previously written value.
- Sweep LATENCY=1 and LATENCY=5 with BASE_ADDR=0x1000; write/read 0x13FC -> MemDone at 1 and 5 cycles respectively; 0x0FFC and 0x1400 return MemErr=1.
